// File: rtl/pattern_serializer.sv
// Serial transmitter: shifts a WIDTH-bit pattern out MSB-first, repeat_count
// times back-to-back, after a valid/ready load. All outputs are registered.
module pattern_serializer #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned CNT_W    = 4,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_count,
    input  logic             abort,
    output logic             x,
    output logic             frame_start,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] copies_q, copies_d;
    logic             x_q, x_d;
    logic             load_ready_q, load_ready_d;
    logic             frame_start_q, frame_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    // The register rotates so the bit currently on x always sits at the MSB;
    // after WIDTH rotations it is back to the original pattern for the next copy.
    logic [WIDTH-1:0] shift_rot;
    logic [CNT_W-1:0] copies_dec;

    assign shift_rot  = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};
    assign copies_dec = copies_q - CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            copies_q      <= '0;
            x_q           <= IDLE_BIT;
            load_ready_q  <= 1'b1;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            copies_q      <= copies_d;
            x_q           <= x_d;
            load_ready_q  <= load_ready_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
        end
    end

    // Next-state logic; the registered outputs describe the cycle after the edge.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        copies_d      = copies_q;
        x_d           = IDLE_BIT;
        frame_start_d = 1'b0;
        done_d        = 1'b0;
        aborted_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_valid && load_ready_q) begin
                    shift_d   = pattern;
                    copies_d  = repeat_count;
                    bit_cnt_d = '0;
                    if (repeat_count != '0) begin
                        state_d       = ST_SEND;
                        x_d           = pattern[WIDTH-1];
                        frame_start_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (abort) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b1;
                end else if (bit_cnt_q == LAST_BIT) begin
                    copies_d = copies_dec;
                    if (copies_dec == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_cnt_d     = '0;
                        shift_d       = shift_rot;
                        x_d           = shift_rot[WIDTH-1];
                        frame_start_d = 1'b1;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    shift_d   = shift_rot;
                    x_d       = shift_rot[WIDTH-1];
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d       = (state_d == ST_SEND);
        load_ready_d = (state_d == ST_IDLE);
    end

    assign x           = x_q;
    assign load_ready  = load_ready_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign aborted     = aborted_q;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer: per-cycle expected output vectors
// {x, frame_start, busy, load_ready, done, aborted} are queued when a load is driven.
module tb_pattern_serializer;

    localparam int unsigned WIDTH = 6;
    localparam int unsigned CNT_W = 4;

    localparam logic [5:0] IDLE_V  = 6'b000100;
    localparam logic [5:0] DONE_V  = 6'b000110;
    localparam logic [5:0] ABORT_V = 6'b000101;

    logic             clock;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [CNT_W-1:0] repeat_count;
    logic             abort;
    logic             x;
    logic             frame_start;
    logic             busy;
    logic             done;
    logic             aborted;

    logic [5:0] sb[$];
    logic [5:0] exp_v;
    int         total;
    int         bad;
    int         n;

    pattern_serializer #(
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W),
        .IDLE_BIT(1'b0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .pattern     (pattern),
        .repeat_count(repeat_count),
        .abort       (abort),
        .x           (x),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [5:0] obs_v();
        return {x, frame_start, busy, load_ready, done, aborted};
    endfunction

    // Expected bit cycles for cnt copies of pat followed by the done cycle.
    task automatic push_frame(input logic [5:0] pat, input int cnt);
        for (int r = 0; r < cnt; r++) begin
            for (int b = 0; b < 6; b++) begin
                sb.push_back({pat[5-b], (b == 0), 1'b1, 1'b0, 1'b0, 1'b0});
            end
        end
        sb.push_back(DONE_V);
    endtask

    // Presents a load one cycle, then returns just after the accepting edge.
    task automatic start_load(input logic [5:0] pat, input logic [3:0] cnt, input bit hold);
        @(posedge clock); #1;
        load_valid   = 1'b1;
        pattern      = pat;
        repeat_count = cnt;
        @(posedge clock); #1;
        if (!hold) load_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        sb.push_back(IDLE_V);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs_v(), exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        start_load(6'b101010, 4'd1, 1'b0);
        push_frame(6'b101010, 1);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL single cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
        end
    endtask

    task automatic test_repeat();
        start_load(6'b101010, 4'd3, 1'b0);
        push_frame(6'b101010, 3);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL repeat cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
        end
    endtask

    // Count-0 load, then load_valid held so each done cycle accepts the next load.
    task automatic test_back_to_back();
        start_load(6'b111111, 4'd0, 1'b1);
        pattern      = 6'b110011;
        repeat_count = 4'd1;
        sb.push_back(DONE_V);
        push_frame(6'b110011, 1);
        push_frame(6'b110011, 1);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
            if (i == 14) load_valid = 1'b0;
        end
    endtask

    task automatic test_ignored_load();
        start_load(6'b101010, 4'd2, 1'b0);
        push_frame(6'b101010, 2);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL ignored_load cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
            if (i == 2) begin
                load_valid   = 1'b1;
                pattern      = 6'b000111;
                repeat_count = 4'd5;
            end
            if (i == 5) load_valid = 1'b0;
        end
    endtask

    task automatic test_abort_mid();
        start_load(6'b111000, 4'd2, 1'b0);
        for (int b = 0; b < 4; b++) begin
            sb.push_back({(b < 3), (b == 0), 1'b1, 1'b0, 1'b0, 1'b0});
        end
        sb.push_back(ABORT_V);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL abort_mid cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
            if (i == 3) abort = 1'b1;
            if (i == 4) abort = 1'b0;
        end
    endtask

    task automatic test_abort_last();
        start_load(6'b111000, 4'd1, 1'b0);
        for (int b = 0; b < 6; b++) begin
            sb.push_back({(b < 3), (b == 0), 1'b1, 1'b0, 1'b0, 1'b0});
        end
        sb.push_back(ABORT_V);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL abort_last cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
            if (i == 5) abort = 1'b1;
            if (i == 6) abort = 1'b0;
        end
    endtask

    // abort while idle must not block a load accepted on the same edge.
    task automatic test_abort_idle();
        @(posedge clock); #1;
        abort = 1'b1;
        start_load(6'b100001, 4'd1, 1'b0);
        abort = 1'b0;
        push_frame(6'b100001, 1);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_load(6'b101010, 4'd3, 1'b0);
        for (int b = 0; b < 5; b++) begin
            sb.push_back({(b % 2 == 0), (b == 0), 1'b1, 1'b0, 1'b0, 1'b0});
        end
        sb.push_back(IDLE_V);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL reset_mid cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
            if (i == 4) reset = 1'b1;
            if (i == 6) reset = 1'b0;
        end
        start_load(6'b110100, 4'd2, 1'b0);
        push_frame(6'b110100, 2);
        sb.push_back(IDLE_V);
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            exp_v = sb.pop_front();
            total++;
            if (obs_v() !== exp_v) begin
                bad++;
                $display("FAIL reset_reload cyc=%0d got=%b exp=%b", i + 1, obs_v(), exp_v);
            end
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        load_valid   = 1'b0;
        pattern      = '0;
        repeat_count = '0;
        abort        = 1'b0;

        test_reset();
        test_single();
        test_repeat();
        test_back_to_back();
        test_ignored_load();
        test_abort_mid();
        test_abort_last();
        test_abort_idle();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
